// File: rtl/x2_bist_pkg.sv
// x2_bist_pkg: shared state encoding, sizes and MISR tap rule for the x2 BIST controller
package x2_bist_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, DONE} bist_state_t;
  localparam int X2_N_IN = 10;
  localparam int X2_N_OUT = 7;
  localparam int N_PAT = 1 << X2_N_IN;
  // Shift-and-xor compaction; only the low n bits of the result are meaningful.
  function automatic logic [31:0] misr_next(input logic [31:0] misr, input logic [31:0] d, input int n);
    logic [31:0] r;
    r = {misr[30:0], 1'b0} ^ d;
    r[0] = misr[n-1] ^ misr[n-2] ^ d[0];
    return r;
  endfunction
endpackage

// File: rtl/x2_misr.sv
// x2_misr: multiple-input signature register compacting netlist responses
module x2_misr
  import x2_bist_pkg::*;
#(
  parameter int N_OUT = X2_N_OUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [N_OUT-1:0] seed,
  input  logic             en,
  input  logic [N_OUT-1:0] d,
  output logic [N_OUT-1:0] q
);
  // Seed takes precedence over a capture so a restart always begins clean.
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (load) q <= seed;
    else if (en) q <= N_OUT'(misr_next(32'(q), 32'(d), N_OUT));
endmodule

// File: rtl/x2_bist_ctrl.sv
// x2_bist_ctrl: exhaustive-pattern BIST controller with settle wait and MISR signature check
module x2_bist_ctrl
  import x2_bist_pkg::*;
#(
  parameter int              N_IN       = X2_N_IN,
  parameter int              N_OUT      = X2_N_OUT,
  parameter int              SETTLE     = 2,
  parameter logic [N_OUT-1:0] MISR_SEED  = '0,
  parameter logic [N_OUT-1:0] GOLDEN_SIG = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  dut_in,
  input  logic [N_OUT-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic [N_OUT-1:0] sig,
  output logic             pass
);
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] RELOAD = SW'(SETTLE - 1);
  bist_state_t state, nxt;
  logic [SW-1:0] settle_cnt;
  logic run, last, en;
  assign run  = (state == IDLE || state == DONE) && start;
  assign last = &dut_in;
  assign en   = state == CAPTURE && !abort;
  // Next state: abort beats the normal sequence; start only counts when not busy.
  always_comb begin
    nxt = state;
    nxt = run ? WAIT :
          state == WAIT    ? (abort ? IDLE : settle_cnt == '0 ? CAPTURE : WAIT) :
          state == CAPTURE ? (abort ? IDLE : last ? DONE : WAIT) : state;
  end
  // State, pattern and settle counters; dut_in moves only at run start or after a capture.
  always_ff @(posedge clk)
    if (rst) begin
      state      <= IDLE;
      dut_in     <= '0;
      settle_cnt <= '0;
    end else begin
      state <= nxt;
      if (run) begin
        dut_in     <= '0;
        settle_cnt <= RELOAD;
      end else if (state == WAIT && !abort && settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
      else if (en && !last) begin
        dut_in     <= dut_in + 1'b1;
        settle_cnt <= RELOAD;
      end
    end
  x2_misr #(.N_OUT(N_OUT)) u_misr (
    .clk (clk),
    .rst (rst),
    .load(run),
    .seed(MISR_SEED),
    .en  (en),
    .d   (dut_out),
    .q   (sig)
  );
  assign busy = state == WAIT || state == CAPTURE;
  assign done = state == DONE;
  assign pass = done && sig == GOLDEN_SIG;
endmodule

// File: doc/x2_bist_ctrl.md
# x2_bist_ctrl

Built-in self-test controller for the `x2` mapped combinational netlist (10 inputs a..j, 7 outputs k..q). It applies every input pattern exhaustively and waits a programmable settle time per pattern. It compacts the responses into a 7-bit MISR signature and compares that signature against a golden value. It sits beside the netlist instance in the toy-benchmark test harness and owns the netlist's input bus while a run is active.

## Interface
Parameters:
- `N_IN`, 10: pattern width; run length is 2^N_IN patterns.
- `N_OUT`, 7: response width; also the MISR width.
- `SETTLE`, 2: wait cycles per pattern before capture; must be ≥1.
- `MISR_SEED`, 7'h00: MISR value loaded at run start.
- `GOLDEN_SIG`, 7'h00: expected final signature.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  run request; sampled only in IDLE or DONE.
- `abort`  in  1  synchronous abort of an active run.
- `dut_in`  out  N_IN  registered pattern to the netlist; bit N_IN-1 = `a`, bit 0 = `j`.
- `dut_out`  in  N_OUT  netlist response; bit N_OUT-1 = `k`, bit 0 = `q`.
- `busy`  out  1  high in WAIT and CAPTURE.
- `done`  out  1  high in DONE.
- `sig`  out  N_OUT  current MISR value.
- `pass`  out  1  `done && sig == GOLDEN_SIG`.

## Operation
- States: IDLE, WAIT, CAPTURE, DONE.
- IDLE:
  - `start=1` → WAIT.
  - Same edge loads `dut_in<=0`, `misr<=MISR_SEED`, `settle_cnt<=SETTLE-1`.
- WAIT:
  - `settle_cnt==0` → CAPTURE.
  - Otherwise decrement `settle_cnt`.
- CAPTURE:
  - MISR update with d=`dut_out`:
    - `next[0] = misr[N_OUT-1] ^ misr[N_OUT-2] ^ d[0]`
    - `next[i] = misr[i-1] ^ d[i]` for i≥1
  - Polynomial for N_OUT=7 is x^7+x^6+1.
  - If `dut_in` is all ones → DONE.
  - Otherwise `dut_in<=dut_in+1` (no wrap), reload `settle_cnt<=SETTLE-1`, → WAIT.
- DONE:
  - `sig` and `dut_in` are held.
  - `start=1` restarts the run exactly as from IDLE.
- `abort=1` in WAIT or CAPTURE → IDLE on the next edge.
  - No MISR update happens on that edge.
  - `sig` holds its partial value; `dut_in` holds.
  - `abort` in IDLE or DONE has no effect.
- Priority: `rst` > `abort` > `start`.
- `start` while busy is ignored; there is no queuing.
- `dut_in` only changes on the CAPTURE→WAIT edge or at run start. It is glitch-free at the register output.

## Timing
- Reset values: state=IDLE, `dut_in=0`, `sig=0`, `busy=0`, `done=0`, `pass=0`, `settle_cnt=0`.
- `rst` asserted mid-run returns to the reset values on the next edge. It overrides `start`/`abort` on that same edge.
- Each pattern occupies SETTLE+1 cycles: SETTLE in WAIT, 1 in CAPTURE.
- With `start` sampled at edge T:
  - `busy=1` from T+1.
  - Final capture occurs at edge T+2^N_IN·(SETTLE+1).
  - `done=1` and `pass` are valid from the following cycle.
- `dut_out` is sampled in CAPTURE, at least SETTLE full cycles after `dut_in` last changed.
- `sig` reflects a capture one cycle after the CAPTURE edge.
- Outputs are all registered, except `pass`, which is a compare on registered state.

## Structure
- Package `x2_bist_pkg` holds:
  - the state enum `bist_state_t` (IDLE/WAIT/CAPTURE/DONE);
  - the localparam `N_PAT = 1<<N_IN`;
  - the function `misr_next(misr, d)` implementing the tap rule above.
- Sub-module `x2_misr` (N_OUT-wide, with `load`/`seed`/`en`/`d` inputs) holds the compaction register.
- The FSM, settle counter and pattern counter live in `x2_bist_ctrl`.
- The `x2` netlist is instantiated by the harness, not inside this block.

## Test plan
- Reset, then idle with `start=0` → `dut_in=0`, `sig=0`, `busy=0`, `done=0`, `pass=0`, held indefinitely.
- N_IN=2, SETTLE=2, seed 0, `dut_out` tied 0, `start` at edge T →
  - `dut_in` steps 0,1,2,3 at T+1, T+4, T+7, T+10;
  - `done=1` at T+13, `sig=7'h00`, `pass=1` with GOLDEN_SIG=0.
- N_IN=1, SETTLE=1, seed 0, `dut_out` tied 7'h01 → `sig` goes 7'h01 after the first capture and 7'h03 after the second; `done` at T+5.
- Full N_IN=10 run with the `x2` netlist attached → exactly 1024 captures, `done` at T+3073. Set GOLDEN_SIG from the gate-level reference model; `pass=1`. Flip one netlist output (bench fault injection) → `pass=0`.
- `abort` during pattern 5 → IDLE next cycle, `busy=0`, `done=0`. A subsequent `start` reruns from `dut_in=0` with MISR reseeded and gives the same final `sig` as an uninterrupted run.
- `start` held high throughout a run → no restart while busy. `rst` pulse at pattern 3 → all outputs back to reset values on the next cycle.
